// File: rtl/cic1_pkg.sv
// Shared helpers for the single-stage CIC decimator: width math and sample types.
package cic1_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Accumulator width that holds the full CIC gain of R*M without loss.
    function automatic int acc_width(input int inp_dw, input int cic_r, input int cic_m);
        return inp_dw + clog2(cic_r * cic_m);
    endfunction

    localparam int DEF_SAMP_DW = 18;
    typedef logic signed [DEF_SAMP_DW-1:0] cic1_samp_t;

endpackage

// File: rtl/cic1_comb.sv
// Comb stage: CIC_M-deep delay line, subtract, output slice (CIC1_ROUND_EN selects rounding).
module cic1_comb
    import cic1_pkg::*;
#(
    parameter int ACC_DW = 20,
    parameter int OUT_DW = 18,
    parameter int CIC_M  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [ACC_DW-1:0] ds_data,
    input  logic                     ds_str,
    output logic signed [OUT_DW-1:0] out_data,
    output logic                     out_str
);

    logic signed [ACC_DW-1:0] z_q [CIC_M];
    logic signed [ACC_DW-1:0] z_d [CIC_M];
    logic signed [ACC_DW-1:0] diff;
    logic signed [OUT_DW-1:0] slice;
    logic signed [OUT_DW-1:0] out_data_q, out_data_d;
    logic                     out_str_q, out_str_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        z_d        = z_q;
        out_data_d = out_data_q;
        out_str_d  = ds_str;
        diff       = ds_data - z_q[CIC_M-1];
        if (ds_str) begin
            z_d[0] = ds_data;
            for (int i = 1; i < CIC_M; i++) begin
                z_d[i] = z_q[i-1];
            end
            out_data_d = slice;
        end
    end

    generate
        if (OUT_DW == ACC_DW) begin : g_full
            assign slice = diff;
        end else begin : g_slice
            localparam int SH = ACC_DW - OUT_DW;
            logic unused_lsbs;
            assign unused_lsbs = ^{1'b0, diff[SH-1:0]};
`ifdef CIC1_ROUND_EN
            // Adding half an LSB then flooring equals adding the first discarded bit.
            logic [OUT_DW:0] rnd;
            assign rnd   = {diff[ACC_DW-1], diff[ACC_DW-1 -: OUT_DW]} + (OUT_DW+1)'(diff[SH-1]);
            assign slice = (rnd[OUT_DW] != rnd[OUT_DW-1]) ? {1'b0, {(OUT_DW-1){1'b1}}}
                                                          : rnd[OUT_DW-1:0];
`else
            assign slice = diff[ACC_DW-1 -: OUT_DW];
`endif
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the delay line is reset because the start-up transient relies on it reading zero.
            for (int i = 0; i < CIC_M; i++) begin
                z_q[i] <= '0;
            end
            out_data_q <= '0;
            out_str_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment only.
            z_q        <= z_d;
            out_data_q <= out_data_d;
            out_str_q  <= out_str_d;
        end
    end

    assign out_data = out_data_q;
    assign out_str  = out_str_q;

endmodule

// File: rtl/cic1_core.sv
// Single-stage CIC decimator: integrator -> downsample by CIC_R -> comb of delay CIC_M.
// Optional macro CIC1_ROUND_EN: round half-up with positive saturation instead of truncation.
module cic1_core
    import cic1_pkg::*;
#(
    parameter int INP_DW = 18,
    parameter int OUT_DW = 18,
    parameter int CIC_R  = 100,
    parameter int CIC_M  = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [INP_DW-1:0] inp_samp_data,
    input  logic                     inp_samp_str,
    output logic signed [OUT_DW-1:0] out_samp_data,
    output logic                     out_samp_str
);

    localparam int ACC_DW = acc_width(INP_DW, CIC_R, CIC_M);
    localparam int CNT_DW = clog2(CIC_R);

    logic signed [ACC_DW-1:0] acc_q, acc_d;
    logic signed [ACC_DW-1:0] ds_data_q, ds_data_d;
    logic [CNT_DW-1:0]        cnt_q, cnt_d;
    logic                     int_str_q, int_str_d;
    logic                     ds_str_q, ds_str_d;

    always_comb begin
        acc_d     = acc_q;
        ds_data_d = ds_data_q;
        cnt_d     = cnt_q;
        int_str_d = inp_samp_str;
        ds_str_d  = 1'b0;
        // Two's-complement wrap is intended; the comb difference undoes it.
        if (inp_samp_str) begin
            acc_d = acc_q + ACC_DW'(inp_samp_data);
        end
        if (int_str_q) begin
            if (cnt_q == CNT_DW'(CIC_R - 1)) begin
                cnt_d     = '0;
                ds_data_d = acc_q;
                ds_str_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            acc_q     <= '0;
            ds_data_q <= '0;
            cnt_q     <= '0;
            int_str_q <= 1'b0;
            ds_str_q  <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            ds_data_q <= ds_data_d;
            cnt_q     <= cnt_d;
            int_str_q <= int_str_d;
            ds_str_q  <= ds_str_d;
        end
    end

    cic1_comb #(
        .ACC_DW (ACC_DW),
        .OUT_DW (OUT_DW),
        .CIC_M  (CIC_M)
    ) u_comb (
        .clk      (clk),
        .rst      (reset_n),
        .ds_data  (ds_data_q),
        .ds_str   (ds_str_q),
        .out_data (out_samp_data),
        .out_str  (out_samp_str)
    );

endmodule

// File: tb/tb_cic1_core.sv
// Directed bench: three cic1_core builds (R=4, INP_DW=8) share one stimulus stream.
module tb_cic1_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic signed [7:0] inp_data;
    logic              inp_str;
    logic signed [9:0] out_a;
    logic signed [7:0] out_b;
    logic signed [8:0] out_c;
    logic              str_a, str_b, str_c;

    // a: M=1 full width (ACC 10), b: M=1 OUT 8, c: M=2 OUT 9 (ACC 11)
    cic1_core #(.INP_DW(8), .OUT_DW(10), .CIC_R(4), .CIC_M(1)) u_a (
        .clk(clk), .reset_n(reset_n), .inp_samp_data(inp_data), .inp_samp_str(inp_str),
        .out_samp_data(out_a), .out_samp_str(str_a));
    cic1_core #(.INP_DW(8), .OUT_DW(8), .CIC_R(4), .CIC_M(1)) u_b (
        .clk(clk), .reset_n(reset_n), .inp_samp_data(inp_data), .inp_samp_str(inp_str),
        .out_samp_data(out_b), .out_samp_str(str_b));
    cic1_core #(.INP_DW(8), .OUT_DW(9), .CIC_R(4), .CIC_M(2)) u_c (
        .clk(clk), .reset_n(reset_n), .inp_samp_data(inp_data), .inp_samp_str(inp_str),
        .out_samp_data(out_c), .out_samp_str(str_c));

`ifdef CIC1_ROUND_EN
    localparam int RND_B = 1;
    localparam int RND_C = 1;
`else
    localparam int RND_B = 0;
    localparam int RND_C = 0;
`endif

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int qa[$], qb[$], qc[$], ca[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (str_a) begin
            qa.push_back(int'(out_a));
            ca.push_back(cyc);
        end
        if (str_b) qb.push_back(int'(out_b));
        if (str_c) qc.push_back(int'(out_c));
    end

    task automatic drive(input logic signed [7:0] d, input logic s);
        @(posedge clk);
        #1;
        inp_data = d;
        inp_str  = s;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'sd0, 1'b0);
    endtask

    task automatic clear_q();
        qa.delete();
        qb.delete();
        qc.delete();
        ca.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        inp_str  = 1'b0;
        inp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        clear_q();
    endtask

    task automatic test_reset();
        reset_n  = 1'b1;
        inp_str  = 1'b0;
        inp_data = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (out_a !== 10'sd0 || str_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_a: data=%0d str=%b, want 0/0", out_a, str_a);
        end
        n_vec++;
        if (out_b !== 8'sd0 || str_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_b: data=%0d str=%b, want 0/0", out_b, str_b);
        end
        n_vec++;
        if (out_c !== 9'sd0 || str_c !== 1'b0) begin
            n_err++;
            $display("FAIL reset_c: data=%0d str=%b, want 0/0", out_c, str_c);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        clear_q();
    endtask

    task automatic test_dc_back_to_back();
        int ea[4] = '{4, 4, 4, 4};
        int eb[4] = '{1, 1, 1, 1};
        int ec[4] = '{1, 2, 2, 2};
        repeat (16) drive(8'sd1, 1'b1);
        idle(8);
        n_vec++;
        if (qa.size() != 4 || qb.size() != 4 || qc.size() != 4) begin
            n_err++;
            $display("FAIL dc_count: got %0d/%0d/%0d strobes, want 4/4/4", qa.size(), qb.size(), qc.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (i >= qa.size() || i >= qb.size() || i >= qc.size() ||
                qa[i] != ea[i] || qb[i] != eb[i] || qc[i] != ec[i]) begin
                n_err++;
                $display("FAIL dc_value[%0d]: got %0d/%0d/%0d, want %0d/%0d/%0d", i,
                         (i < qa.size()) ? qa[i] : -9999, (i < qb.size()) ? qb[i] : -9999,
                         (i < qc.size()) ? qc[i] : -9999, ea[i], eb[i], ec[i]);
            end
            if (i > 0 && i < ca.size()) begin
                n_vec++;
                if (ca[i] - ca[i-1] != 4) begin
                    n_err++;
                    $display("FAIL dc_spacing[%0d]: got %0d cycles, want 4", i, ca[i] - ca[i-1]);
                end
            end
        end
    endtask

    task automatic test_latency();
        int c4;
        do_reset();
        repeat (3) drive(8'sd1, 1'b1);
        drive(8'sd1, 1'b1);
        c4 = cyc;
        idle(8);
        n_vec++;
        if (qa.size() != 1) begin
            n_err++;
            $display("FAIL latency_count: got %0d strobe cycles, want 1", qa.size());
        end
        n_vec++;
        if (ca.size() < 1 || ca[0] != c4 + 3) begin
            n_err++;
            $display("FAIL latency_cycle: got %0d, want %0d", (ca.size() > 0) ? ca[0] : -1, c4 + 3);
        end
        n_vec++;
        if (qa.size() < 1 || qa[0] != 4) begin
            n_err++;
            $display("FAIL latency_value: got %0d, want 4", (qa.size() > 0) ? qa[0] : -9999);
        end
    endtask

    task automatic test_sparse();
        int ea[3] = '{-8, -8, -8};
        int eb[3] = '{-2, -2, -2};
        int ec[3] = '{-2, -4, -4};
        do_reset();
        repeat (12) begin
            drive(-8'sd2, 1'b1);
            idle(2);
        end
        idle(6);
        n_vec++;
        if (qa.size() != 3 || qb.size() != 3 || qc.size() != 3) begin
            n_err++;
            $display("FAIL sparse_count: got %0d/%0d/%0d strobes, want 3/3/3", qa.size(), qb.size(), qc.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= qa.size() || i >= qb.size() || i >= qc.size() ||
                qa[i] != ea[i] || qb[i] != eb[i] || qc[i] != ec[i]) begin
                n_err++;
                $display("FAIL sparse_value[%0d]: got %0d/%0d/%0d, want %0d/%0d/%0d", i,
                         (i < qa.size()) ? qa[i] : -9999, (i < qb.size()) ? qb[i] : -9999,
                         (i < qc.size()) ? qc[i] : -9999, ea[i], eb[i], ec[i]);
            end
            if (i > 0 && i < ca.size()) begin
                n_vec++;
                if (ca[i] - ca[i-1] != 12) begin
                    n_err++;
                    $display("FAIL sparse_spacing[%0d]: got %0d cycles, want 12", i, ca[i] - ca[i-1]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int ec;
        do_reset();
        repeat (100) drive(8'sd127, 1'b1);
        idle(8);
        n_vec++;
        if (qa.size() != 25 || qb.size() != 25 || qc.size() != 25) begin
            n_err++;
            $display("FAIL wrap_count: got %0d/%0d/%0d strobes, want 25/25/25", qa.size(), qb.size(), qc.size());
        end
        for (int i = 0; i < qa.size() && i < qb.size() && i < qc.size(); i++) begin
            ec = (i == 0) ? 127 : 254;
            n_vec++;
            if (qa[i] != 508 || qb[i] != 127 || qc[i] != ec) begin
                n_err++;
                $display("FAIL wrap_value[%0d]: got %0d/%0d/%0d, want 508/127/%0d", i, qa[i], qb[i], qc[i], ec);
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (2) drive(8'sd5, 1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        inp_str = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_a !== 10'sd0 || str_a !== 1'b0 || out_c !== 9'sd0 || str_c !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_clear: got a=%0d/%b c=%0d/%b, want 0/0 0/0", out_a, str_a, out_c, str_c);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        clear_q();
        repeat (4) drive(8'sd1, 1'b1);
        idle(8);
        n_vec++;
        if (qa.size() != 1 || qb.size() != 1 || qc.size() != 1) begin
            n_err++;
            $display("FAIL midreset_count: got %0d/%0d/%0d strobes, want 1/1/1", qa.size(), qb.size(), qc.size());
        end else begin
            n_vec++;
            if (qa[0] != 4 || qb[0] != 1 || qc[0] != 1) begin
                n_err++;
                $display("FAIL midreset_value: got %0d/%0d/%0d, want 4/1/1", qa[0], qb[0], qc[0]);
            end
        end
    endtask

    task automatic test_round();
        do_reset();
        drive(8'sd1, 1'b1);
        drive(8'sd1, 1'b1);
        drive(8'sd0, 1'b1);
        drive(8'sd0, 1'b1);
        idle(8);
        n_vec++;
        if (qa.size() != 1 || qb.size() != 1 || qc.size() != 1) begin
            n_err++;
            $display("FAIL round_count: got %0d/%0d/%0d strobes, want 1/1/1", qa.size(), qb.size(), qc.size());
        end else begin
            n_vec++;
            if (qa[0] != 2 || qb[0] != RND_B || qc[0] != RND_C) begin
                n_err++;
                $display("FAIL round_value: got %0d/%0d/%0d, want 2/%0d/%0d", qa[0], qb[0], qc[0], RND_B, RND_C);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_dc_back_to_back();
        test_latency();
        test_sparse();
        test_wrap();
        test_reset_mid();
        test_round();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
